maxpool_sequencer: RTL and testbench
====================================

# maxpool_sequencer

Controller that runs NUM_CH stored feature maps, one at a time, through a single shared 2x2/stride-2 max-pool engine. For each channel it reads the MAP_WIDTH×MAP_WIDTH input map from the feature-map RAM in raster order and holds the engine in reset between channels. It collects the engine's OUT_DIM² results and writes them into the pooled-map RAM. It sits between the conv-layer output buffer and the next layer's input buffer; the top level instantiates the engine and wires it to this block.

## Interface
- MAP_WIDTH, 28, input map side length; must be even.
- NUM_CH, 6, number of channels processed per start.
- OUT_DIM, MAP_WIDTH/2, pooled map side length.
- IN_AW, $clog2(NUM_CH*MAP_WIDTH*MAP_WIDTH), input RAM address width.
- OUT_AW, $clog2(NUM_CH*OUT_DIM*OUT_DIM), output RAM address width.

- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- stall  in  1  input RAM not available this cycle; no read issued.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last pooled value of the last channel is written.
- rd_en  out  1  input RAM read strobe.
- rd_addr  out  IN_AW  input RAM address, ch*MAP_WIDTH² + pixel index.
- rd_data  in  8  signed pixel; valid exactly 1 cycle after rd_en.
- eng_rst  out  1  engine reset.
- eng_valid_in  out  1  pixel valid to engine.
- eng_pixel_in  out  8  signed pixel to engine.
- eng_valid_out  in  1  engine result valid.
- eng_pixel_out  in  8  signed engine result.
- wr_en  out  1  output RAM write strobe.
- wr_addr  out  OUT_AW  output address, ch*OUT_DIM² + result index.
- wr_data  out  8  signed pooled value.

## Operation
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: waits for start. On start, sets ch=0 and goes to CLEAR.
- CLEAR: asserts eng_rst for exactly one cycle, zeroes the pixel counter and the result counter, then goes to STREAM.
- STREAM: issues one read per cycle when stall=0. The pixel counter runs 0..MAP_WIDTH²-1. The cycle that issues the last read goes to DRAIN.
- DRAIN: waits until the result counter reaches OUT_DIM². Then it goes to CLEAR with ch+1, or to DONE if ch=NUM_CH-1.
- DONE: pulses done for one cycle, drops busy, returns to IDLE.
- Engine feed: eng_valid_in = registered rd_en; eng_pixel_in = rd_data. A stall therefore produces a gap in eng_valid_in, which the engine tolerates.
- Each eng_valid_out is registered to wr_en/wr_data/wr_addr, and the result counter increments.
- eng_all_done is not used; completion is tracked only by the result counter.
- Pixel values pass through unmodified; the block does no arithmetic on them.
- eng_rst = rst OR (state==CLEAR).

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, eng_valid_in=0, eng_pixel_in=0, wr_en=0, wr_addr=0, wr_data=0, state=IDLE, ch=0. eng_rst=1 while rst is high.
- start at cycle 0: CLEAR at cycle 1, first rd_en at cycle 2, first eng_valid_in at cycle 3.
- Engine result at eng_valid_out edge E: wr_en is high in cycle E+1.
- With no stalls, a channel takes MAP_WIDTH²+4 cycles from CLEAR to the next CLEAR.
- done is asserted the cycle after the final wr_en.
- stall held high: rd_en stays low and the counters hold; no timeout.
- start arriving while busy is dropped without effect; a start coinciding with done is also dropped.
- rst mid-run: the FSM returns to IDLE on the next edge and all outputs take their reset values. Partially written output RAM contents are left as they are.
- NUM_CH=1 is legal: the FSM passes CLEAR→STREAM→DRAIN→DONE once.

## Structure
- Package maxpool_pkg holds the state enum type, pixel_t (logic signed [7:0]), and the address-width helper functions.
- Sub-module: maxpool_addr_gen, which holds the channel, pixel and result counters and computes the base-plus-offset rd_addr and wr_addr. The FSM stays in maxpool_sequencer.

## Test plan
All scenarios use MAP_WIDTH=4, NUM_CH=2, a behavioural engine model and a 1-cycle-latency RAM model.
- Channel 0 pixels 0..15, no stall: wr_addr 0..3 receive 5, 7, 13, 15; done pulses once; busy lasts exactly 2×20+1 cycles.
- Channel 1 pixels -16..-1: wr_addr 4..7 receive -11, -9, -3, -1, confirming signed max across the channel boundary.
- stall high in cycles 4..9 of channel 0: there are no rd_en in that window, and the results are identical to the no-stall run.
- eng_rst is high for exactly one cycle before each channel, with no eng_valid_in on the same cycle.
- rst asserted in the middle of channel 1's STREAM: all outputs return to their reset values on the next edge; a new start then produces the full correct run.
- start re-pulsed while busy: run length and results are unchanged, and only one done pulse occurs.

Source files
------------

// File: rtl/maxpool_pkg.sv
// maxpool_pkg
// Shared types and helpers for the max-pool sequencer slice.
//   state_t    : sequencer FSM states
//   pixel_t    : signed 8-bit pixel / pooled value
//   in_addr_w  : feature-map RAM address width for a given map side and channel count
//   out_addr_w : pooled-map RAM address width for a given pooled side and channel count
package maxpool_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef logic signed [7:0] pixel_t;

    // Never returns 0 so that a degenerate depth still yields a legal vector.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned in_addr_w(input int unsigned map_width,
                                              input int unsigned num_ch);
        return clog2_min1(num_ch * map_width * map_width);
    endfunction

    function automatic int unsigned out_addr_w(input int unsigned out_dim,
                                               input int unsigned num_ch);
        return clog2_min1(num_ch * out_dim * out_dim);
    endfunction

endpackage

// File: rtl/maxpool_addr_gen.sv
// maxpool_addr_gen
// Channel, pixel and result counters plus RAM address generation.
// Addresses are a per-channel base register plus the running offset; the
// bases step by one map size per channel, so no multiplier is needed.
//   clk, rst     : clock, synchronous active-high reset
//   i_clr_all    : zero channel, bases and both counters
//   i_clr_cnt    : zero pixel and result counters (start of a channel)
//   i_ch_next    : advance to the next channel
//   i_pix_inc    : a read was issued this cycle
//   i_res_inc    : an engine result was accepted this cycle
//   o_pix_last   : pixel counter is on the last pixel of the map
//   o_res_full   : all pooled results of the channel have been accepted
//   o_ch_last    : current channel is the final one
//   o_rd_addr    : feature-map RAM address of the current pixel
//   o_wr_addr    : pooled-map RAM address of the next result
module maxpool_addr_gen
    import maxpool_pkg::*;
#(
    parameter int unsigned MAP_WIDTH = 28,
    parameter int unsigned NUM_CH    = 6,
    parameter int unsigned OUT_DIM   = MAP_WIDTH / 2,
    parameter int unsigned IN_AW     = in_addr_w(MAP_WIDTH, NUM_CH),
    parameter int unsigned OUT_AW    = out_addr_w(OUT_DIM, NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr_all,
    input  logic              i_clr_cnt,
    input  logic              i_ch_next,
    input  logic              i_pix_inc,
    input  logic              i_res_inc,
    output logic              o_pix_last,
    output logic              o_res_full,
    output logic              o_ch_last,
    output logic [IN_AW-1:0]  o_rd_addr,
    output logic [OUT_AW-1:0] o_wr_addr
);

    localparam int unsigned PIX_N = MAP_WIDTH * MAP_WIDTH;
    localparam int unsigned RES_N = OUT_DIM * OUT_DIM;
    localparam int unsigned PIX_W = clog2_min1(PIX_N);
    localparam int unsigned RES_W = clog2_min1(RES_N + 1);
    localparam int unsigned CH_W  = clog2_min1(NUM_CH);

    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(PIX_N - 1);
    localparam logic [RES_W-1:0]  RES_FULL = RES_W'(RES_N);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [IN_AW-1:0]  IN_STEP  = IN_AW'(PIX_N);
    localparam logic [OUT_AW-1:0] OUT_STEP = OUT_AW'(RES_N);

    logic [CH_W-1:0]   r_ch;
    logic [PIX_W-1:0]  r_pix;
    logic [RES_W-1:0]  r_res;
    logic [IN_AW-1:0]  r_rd_base;
    logic [OUT_AW-1:0] r_wr_base;

    always_ff @(posedge clk) begin
        if (rst || i_clr_all) begin
            r_ch      <= '0;
            r_pix     <= '0;
            r_res     <= '0;
            r_rd_base <= '0;
            r_wr_base <= '0;
        end else begin
            if (i_clr_cnt) begin
                r_pix <= '0;
                r_res <= '0;
            end else begin
                // Wraps after the last pixel so the counter stays in range.
                if (i_pix_inc) begin
                    r_pix <= (r_pix == PIX_LAST) ? '0 : r_pix + 1'b1;
                end
                if (i_res_inc) begin
                    r_res <= r_res + 1'b1;
                end
            end
            if (i_ch_next) begin
                r_ch      <= r_ch + 1'b1;
                r_rd_base <= r_rd_base + IN_STEP;
                r_wr_base <= r_wr_base + OUT_STEP;
            end
        end
    end

    assign o_pix_last = (r_pix == PIX_LAST);
    assign o_res_full = (r_res == RES_FULL);
    assign o_ch_last  = (r_ch == CH_LAST);
    assign o_rd_addr  = r_rd_base + IN_AW'(r_pix);
    assign o_wr_addr  = r_wr_base + OUT_AW'(r_res);

endmodule

// File: rtl/maxpool_sequencer.sv
// maxpool_sequencer
// Runs NUM_CH stored feature maps, one at a time, through a shared external
// 2x2/stride-2 max-pool engine and writes the pooled maps to the output RAM.
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle run request, ignored while busy
//   stall         : input RAM unavailable this cycle, no read issued
//   busy, done    : run in progress / one-cycle completion pulse
//   rd_en/rd_addr : input RAM read strobe and address (data 1 cycle later)
//   rd_data       : signed input pixel
//   eng_rst       : engine reset (global reset or between channels)
//   eng_valid_in, eng_pixel_in   : pixel stream to the engine
//   eng_valid_out, eng_pixel_out : pooled results from the engine
//   wr_en/wr_addr/wr_data        : output RAM write port
module maxpool_sequencer
    import maxpool_pkg::*;
#(
    parameter int unsigned MAP_WIDTH = 28,
    parameter int unsigned NUM_CH    = 6,
    parameter int unsigned OUT_DIM   = MAP_WIDTH / 2,
    parameter int unsigned IN_AW     = in_addr_w(MAP_WIDTH, NUM_CH),
    parameter int unsigned OUT_AW    = out_addr_w(OUT_DIM, NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [IN_AW-1:0]  rd_addr,
    input  logic [7:0]        rd_data,
    output logic              eng_rst,
    output logic              eng_valid_in,
    output logic [7:0]        eng_pixel_in,
    input  logic              eng_valid_out,
    input  logic [7:0]        eng_pixel_out,
    output logic              wr_en,
    output logic [OUT_AW-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_eng_valid_in;
    logic              r_wr_en;
    pixel_t            r_wr_data;
    logic [OUT_AW-1:0] r_wr_addr;

    logic              w_rd_en;
    logic              w_res_acc;
    logic              w_ch_next;
    logic              w_pix_last;
    logic              w_res_full;
    logic              w_ch_last;
    logic [IN_AW-1:0]  w_rd_addr;
    logic [OUT_AW-1:0] w_wr_addr;

    // The read strobe must react to stall in the same cycle, so it is
    // decoded from the registered state rather than registered itself.
    assign w_rd_en   = (r_state == ST_STREAM) && !stall;
    assign w_res_acc = eng_valid_out && ((r_state == ST_STREAM) || (r_state == ST_DRAIN));
    assign w_ch_next = (r_state == ST_DRAIN) && w_res_full && !w_ch_last;

    maxpool_addr_gen #(
        .MAP_WIDTH (MAP_WIDTH),
        .NUM_CH    (NUM_CH),
        .OUT_DIM   (OUT_DIM),
        .IN_AW     (IN_AW),
        .OUT_AW    (OUT_AW)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_clr_all  ((r_state == ST_IDLE) || (r_state == ST_DONE)),
        .i_clr_cnt  (r_state == ST_CLEAR),
        .i_ch_next  (w_ch_next),
        .i_pix_inc  (w_rd_en),
        .i_res_inc  (w_res_acc),
        .o_pix_last (w_pix_last),
        .o_res_full (w_res_full),
        .o_ch_last  (w_ch_last),
        .o_rd_addr  (w_rd_addr),
        .o_wr_addr  (w_wr_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_eng_valid_in <= 1'b0;
            r_wr_en        <= 1'b0;
            r_wr_data      <= '0;
            r_wr_addr      <= '0;
        end else begin
            r_eng_valid_in <= w_rd_en;
            r_wr_en        <= w_res_acc;
            r_done         <= 1'b0;
            if (w_res_acc) begin
                r_wr_data <= pixel_t'(eng_pixel_out);
                r_wr_addr <= w_wr_addr;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_rd_en && w_pix_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_res_full) begin
                        if (w_ch_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_CLEAR;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign rd_en        = w_rd_en;
    assign rd_addr      = w_rd_addr;
    assign eng_rst      = rst || (r_state == ST_CLEAR);
    assign eng_valid_in = r_eng_valid_in;
    // RAM data is only meaningful the cycle after a read; zero otherwise.
    assign eng_pixel_in = r_eng_valid_in ? rd_data : '0;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;

endmodule

// File: tb/tb_maxpool_sequencer.sv
module tb_maxpool_sequencer;

    localparam int MW      = 4;
    localparam int NCH     = 2;
    localparam int OD      = 2;
    localparam int IAW     = 5;
    localparam int OAW     = 3;
    localparam int NPIX    = MW * MW * NCH;
    localparam int NOUT    = OD * OD * NCH;
    localparam int SCHED_N = 256;
    localparam int T_MAX   = 400;
    localparam logic [63:0] RAMP_OUT = 64'hFF_FD_F7_F5_0F_0D_07_05;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           stall;
    logic           busy;
    logic           done;
    logic           rd_en;
    logic [IAW-1:0] rd_addr;
    logic [7:0]     rd_data;
    logic           eng_rst;
    logic           eng_valid_in;
    logic [7:0]     eng_pixel_in;
    logic           eng_valid_out;
    logic [7:0]     eng_pixel_out;
    logic           wr_en;
    logic [OAW-1:0] wr_addr;
    logic [7:0]     wr_data;

    always #5 clk = ~clk;

    maxpool_sequencer #(
        .MAP_WIDTH (MW),
        .NUM_CH    (NCH),
        .OUT_DIM   (OD),
        .IN_AW     (IAW),
        .OUT_AW    (OAW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stall         (stall),
        .busy          (busy),
        .done          (done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .eng_rst       (eng_rst),
        .eng_valid_in  (eng_valid_in),
        .eng_pixel_in  (eng_pixel_in),
        .eng_valid_out (eng_valid_out),
        .eng_pixel_out (eng_pixel_out),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data)
    );

    // ---------------- input RAM model: 1-cycle read latency ----------------
    logic signed [7:0] mem [NPIX];
    int                rd_cnt [NPIX];
    bit                sched [SCHED_N];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data          <= mem[rd_addr];
            rd_cnt[rd_addr]  <= rd_cnt[rd_addr] + 1;
        end
    end

    // ---------------- behavioural 2x2/stride-2 max-pool engine ----------------
    logic signed [7:0] ebuf [MW*MW];
    int                e_cnt;

    function automatic int wrap(input int k);
        return ((k % (MW * MW)) + MW * MW) % (MW * MW);
    endfunction

    function automatic bit win_end(input int k);
        int kk;
        kk = wrap(k);
        return ((kk / MW) % 2 == 1) && ((kk % MW) % 2 == 1);
    endfunction

    function automatic logic signed [7:0] max4(input logic signed [7:0] a, input logic signed [7:0] b,
                                               input logic signed [7:0] c, input logic signed [7:0] d);
        logic signed [7:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    always @(posedge clk) begin
        if (eng_rst) begin
            e_cnt         <= 0;
            eng_valid_out <= 1'b0;
            eng_pixel_out <= '0;
        end else begin
            eng_valid_out <= 1'b0;
            if (eng_valid_in) begin
                ebuf[wrap(e_cnt)] <= eng_pixel_in;
                e_cnt             <= e_cnt + 1;
                if (win_end(e_cnt)) begin
                    eng_valid_out <= 1'b1;
                    eng_pixel_out <= max4(ebuf[wrap(e_cnt - MW - 1)], ebuf[wrap(e_cnt - MW)],
                                          ebuf[wrap(e_cnt - 1)], eng_pixel_in);
                end
            end
        end
    end

    // ---------------- monitors ----------------
    int                cyc = 0;
    int                n_busy, n_done, n_wr, n_erst, n_erise, n_erst_vin, n_rd_stall;
    int                done_cyc, last_wr_cyc;
    bit                erst_prev;
    int                wr_cyc [NOUT];
    logic signed [7:0] outmem [NOUT];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        erst_prev <= eng_rst;
        if (busy) n_busy <= n_busy + 1;
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (eng_rst) n_erst <= n_erst + 1;
        if (eng_rst && !erst_prev) n_erise <= n_erise + 1;
        if (eng_rst && eng_valid_in) n_erst_vin <= n_erst_vin + 1;
        if (stall && rd_en) n_rd_stall <= n_rd_stall + 1;
        if (wr_en) begin
            n_wr             <= n_wr + 1;
            last_wr_cyc      <= cyc;
            wr_cyc[wr_addr]  <= cyc;
            outmem[wr_addr]  <= wr_data;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, ":busy"},         int'(busy), 0);
        chk({tag, ":done"},         int'(done), 0);
        chk({tag, ":rd_en"},        int'(rd_en), 0);
        chk({tag, ":rd_addr"},      int'(rd_addr), 0);
        chk({tag, ":eng_valid_in"}, int'(eng_valid_in), 0);
        chk({tag, ":eng_pixel_in"}, int'(eng_pixel_in), 0);
        chk({tag, ":wr_en"},        int'(wr_en), 0);
        chk({tag, ":wr_addr"},      int'(wr_addr), 0);
        chk({tag, ":wr_data"},      int'(wr_data), 0);
        chk({tag, ":eng_rst"},      int'(eng_rst), 1);
    endtask

    // Pooled value for output address a, straight from the stored maps.
    function automatic int exp_out_model(input int a);
        int ch, i, r, c, base;
        ch   = a / (OD * OD);
        i    = a % (OD * OD);
        r    = i / OD;
        c    = i % OD;
        base = ch * MW * MW + 2 * r * MW + 2 * c;
        return int'(max4(mem[base], mem[base + 1], mem[base + MW], mem[base + MW + 1]));
    endfunction

    function automatic bit st(input int t);
        return (t >= 0 && t < SCHED_N) ? sched[t] : 1'b0;
    endfunction

    // Cycle (relative to start) on which done is high: each channel is one
    // clear cycle, reads on every non-stalled cycle until the map is read,
    // then four cycles to the next channel's clear (or to done).
    function automatic int exp_busy_model();
        int t, tt, reads;
        t = 1;
        for (int ch = 0; ch < NCH; ch++) begin
            tt    = t + 1;
            reads = 0;
            while (reads < MW * MW) begin
                if (!st(tt)) reads++;
                tt++;
            end
            t = (tt - 1) + 4;
        end
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < MW * MW; i++) begin
            mem[i]           = 8'(i);
            mem[MW * MW + i] = 8'(i - 16);
        end
    endtask

    task automatic run_one(input string tag, input int rep, input int exp_busy,
                           input logic [63:0] exp_out, input bit use_tab);
        int  rd0 [NPIX];
        int  s, t, b0, d0, w0, e0, r0, ev0, rs0, bad, act, ex;
        for (int a = 0; a < NPIX; a++) rd0[a] = rd_cnt[a];
        b0 = n_busy; d0 = n_done; w0 = n_wr; e0 = n_erst; r0 = n_erise;
        ev0 = n_erst_vin; rs0 = n_rd_stall;
        s = cyc;
        t = 0;
        while (t < T_MAX && n_done == d0) begin
            start = (t == 0) || (t == rep);
            stall = st(t);
            step();
            start = 1'b0;
            stall = 1'b0;
            t++;
        end
        chk({tag, ":finished"}, int'(n_done != d0), 1);
        repeat (3) step();
        chk({tag, ":idle_after"},      int'(busy), 0);
        chk({tag, ":done_pulses"},     n_done - d0, 1);
        chk({tag, ":busy_cycles"},     n_busy - b0, exp_busy);
        chk({tag, ":done_cycle"},      done_cyc - s, exp_busy);
        chk({tag, ":done_after_wr"},   done_cyc - last_wr_cyc, 1);
        chk({tag, ":writes"},          n_wr - w0, NOUT);
        chk({tag, ":eng_rst_cycles"},  n_erst - e0, NCH);
        chk({tag, ":eng_rst_pulses"},  n_erise - r0, NCH);
        chk({tag, ":eng_rst_valid"},   n_erst_vin - ev0, 0);
        chk({tag, ":rd_during_stall"}, n_rd_stall - rs0, 0);
        bad = 0;
        for (int a = 0; a < NPIX; a++) if (rd_cnt[a] - rd0[a] != 1) bad++;
        chk({tag, ":addr_not_read_once"}, bad, 0);
        for (int a = 0; a < NOUT; a++) begin
            act = (wr_cyc[a] > s) ? int'(outmem[a]) : 1000;
            ex  = use_tab ? int'($signed(exp_out[8 * a +: 8])) : exp_out_model(a);
            chk($sformatf("%s:out[%0d]", tag, a), act, ex);
        end
    endtask

    typedef struct {
        int          stall_lo;
        int          stall_hi;
        int          rep;
        int          exp_busy;
        logic [63:0] exp_out;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{-1, -1, -1, 41, RAMP_OUT};   // plain run
        vecs[1] = '{ 4,  9, -1, 47, RAMP_OUT};   // stall inside channel 0
        vecs[2] = '{15, 25, -1, 52, RAMP_OUT};   // stall spanning channel end
        vecs[3] = '{-1, -1, 10, 41, RAMP_OUT};   // start re-pulsed mid-stream
        vecs[4] = '{-1, -1,  1, 41, RAMP_OUT};   // start re-pulsed during clear
        vecs[5] = '{-1, -1, 41, 41, RAMP_OUT};   // start coincides with done

        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        repeat (3) step();
        chk_rst("reset");
        rst = 1'b0;
        repeat (2) step();

        load_ramp();
        for (int v = 0; v < 6; v++) begin
            for (int t = 0; t < SCHED_N; t++) sched[t] = (t >= vecs[v].stall_lo) && (t <= vecs[v].stall_hi);
            run_one($sformatf("vec%0d", v), vecs[v].rep, vecs[v].exp_busy, vecs[v].exp_out, 1'b1);
        end

        // Reset in the middle of channel 1's stream, then a clean full run.
        for (int t = 0; t < SCHED_N; t++) sched[t] = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (26) step();
        chk("midrst:in_stream", int'(rd_en), 1);
        chk("midrst:busy_before", int'(busy), 1);
        rst = 1'b1;
        step();
        chk_rst("midrst");
        rst = 1'b0;
        step();
        chk("midrst:busy_after", int'(busy), 0);
        chk("midrst:rd_en_after", int'(rd_en), 0);
        step();
        run_one("after_rst", -1, 41, RAMP_OUT, 1'b1);

        // Random pixels and random stall patterns against the reference model.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
            for (int t = 0; t < SCHED_N; t++) sched[t] = ($urandom_range(0, 3) == 0);
            run_one($sformatf("rand%0d", k),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 40)) : -1,
                    exp_busy_model(), '0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
